// File: rtl/processor_param.sv
// rtl/processor_param.sv - parameterised accumulator processor with FETCH/DECODE/EXEC/MEM/WB/HALT sequencing
module processor_param #(
    parameter int DATA_W = 16,
    parameter int IM_AW  = 10,
    parameter int DM_AW  = 11
) (
    input  logic              CLOCK_i,
    input  logic              RESET_i,
    input  logic              HOLD_n_i,
    output logic [IM_AW-1:0]  ADDR_im_o,
    input  logic [DATA_W-1:0] DATA_im_i,
    output logic              CEnable_im_o,
    output logic              OEnable_im_o,
    output logic              CEnable_dm_o,
    output logic              OEnable_dm_o,
    output logic              WEnable_dm_o,
    output logic [DM_AW-1:0]  ADDR_dm_o,
    output logic [DATA_W-1:0] DATA_dm_o,
    input  logic [DATA_W-1:0] DATA_dm_i,
    input  logic              DM_READY_i,
    output logic              HALTED_o,
    output logic [DATA_W-1:0] ACC_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_JN   = 4'hB;
    localparam logic [3:0] OP_JC   = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t            state;
    state_t            state_nxt;
    logic [IM_AW-1:0]  pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] mdr;
    logic              flag_z;
    logic              flag_n;
    logic              flag_c;

    logic [3:0]        opcode;
    logic [3:0]        im_opcode;
    logic [DATA_W-5:0] operand;
    logic [DATA_W:0]   alu_sum;
    logic [DATA_W:0]   alu_diff;

    logic              acc_we;
    logic [DATA_W-1:0] acc_nxt;
    logic              c_we;
    logic              c_nxt;
    logic              jump_take;

    assign opcode    = ir[DATA_W-1 -: 4];
    assign operand   = ir[DATA_W-5:0];
    assign im_opcode = DATA_im_i[DATA_W-1 -: 4];
    assign alu_sum   = {1'b0, acc} + {1'b0, mdr};
    assign alu_diff  = {1'b0, acc} - {1'b0, mdr};

    assign ADDR_im_o = pc;
    assign ADDR_dm_o = ir[DM_AW-1:0];
    assign DATA_dm_o = acc;
    assign ACC_o     = acc;
    assign HALTED_o  = (state == S_HALT);

    // State register; HOLD_n_i low freezes the sequencer in place
    always_ff @(posedge CLOCK_i or posedge RESET_i) begin
        if (RESET_i) begin
            state <= S_FETCH;
        end else if (HOLD_n_i) begin
            state <= state_nxt;
        end
    end

    // Next-state selection; DECODE routes on the opcode arriving from instruction memory
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = ((im_opcode >= OP_LD) && (im_opcode <= OP_XOR)) ? S_MEM : S_EXEC;
            S_EXEC:   state_nxt = (opcode == OP_HALT) ? S_HALT : S_FETCH;
            S_MEM: begin
                if (DM_READY_i) begin
                    state_nxt = (opcode == OP_ST) ? S_FETCH : S_WB;
                end
            end
            S_WB:     state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // Active-low memory strobes; reset forces them inactive without waiting for a clock
    always_comb begin
        CEnable_im_o = 1'b1;
        OEnable_im_o = 1'b1;
        CEnable_dm_o = 1'b1;
        OEnable_dm_o = 1'b1;
        WEnable_dm_o = 1'b1;
        if (!RESET_i) begin
            case (state)
                S_FETCH: begin
                    CEnable_im_o = 1'b0;
                    OEnable_im_o = 1'b0;
                end
                S_MEM: begin
                    CEnable_dm_o = 1'b0;
                    if (opcode == OP_ST) begin
                        WEnable_dm_o = 1'b0;
                    end else begin
                        OEnable_dm_o = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Accumulator, carry and branch decisions for the EXEC and WB steps
    always_comb begin
        acc_we    = 1'b0;
        acc_nxt   = acc;
        c_we      = 1'b0;
        c_nxt     = flag_c;
        jump_take = 1'b0;
        case (state)
            S_EXEC: begin
                case (opcode)
                    OP_LDI: begin
                        acc_we  = 1'b1;
                        acc_nxt = {4'b0000, operand};
                        c_we    = 1'b1;
                        c_nxt   = 1'b0;
                    end
                    OP_JMP:  jump_take = 1'b1;
                    OP_JZ:   jump_take = flag_z;
                    OP_JN:   jump_take = flag_n;
                    OP_JC:   jump_take = flag_c;
                    default: ;
                endcase
            end
            S_WB: begin
                acc_we = 1'b1;
                c_we   = 1'b1;
                c_nxt  = 1'b0;
                case (opcode)
                    OP_LD:  acc_nxt = mdr;
                    OP_ADD: begin
                        acc_nxt = alu_sum[DATA_W-1:0];
                        c_nxt   = alu_sum[DATA_W];
                    end
                    OP_SUB: begin
                        acc_nxt = alu_diff[DATA_W-1:0];
                        c_nxt   = alu_diff[DATA_W];
                    end
                    OP_AND: acc_nxt = acc & mdr;
                    OP_OR:  acc_nxt = acc | mdr;
                    OP_XOR: acc_nxt = acc ^ mdr;
                    default: begin
                        acc_we = 1'b0;
                        c_we   = 1'b0;
                    end
                endcase
            end
            default: ;
        endcase
    end

    // Architectural registers; all frozen while HOLD_n_i is low
    always_ff @(posedge CLOCK_i or posedge RESET_i) begin
        if (RESET_i) begin
            pc     <= '0;
            ir     <= '0;
            acc    <= '0;
            mdr    <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
        end else if (HOLD_n_i) begin
            if (state == S_DECODE) begin
                ir <= DATA_im_i;
                pc <= pc + IM_AW'(1);
            end
            if (jump_take) begin
                pc <= operand[IM_AW-1:0];
            end
            if ((state == S_MEM) && DM_READY_i && (opcode != OP_ST)) begin
                mdr <= DATA_dm_i;
            end
            if (acc_we) begin
                acc    <= acc_nxt;
                flag_z <= (acc_nxt == '0);
                flag_n <= acc_nxt[DATA_W-1];
            end
            if (c_we) begin
                flag_c <= c_nxt;
            end
        end
    end

endmodule

// File: tb/tb_processor_param.sv
// tb/tb_processor_param.sv - instruction-level model checker for processor_param
module tb_processor_param;

    localparam int DW  = 16;
    localparam int IAW = 10;
    localparam int DAW = 11;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           hold_n = 1'b1;
    logic           dm_ready = 1'b1;
    logic [IAW-1:0] addr_im;
    logic [DW-1:0]  data_im = '0;
    logic           ce_im, oe_im, ce_dm, oe_dm, we_dm;
    logic [DAW-1:0] addr_dm;
    logic [DW-1:0]  data_dm_o;
    logic [DW-1:0]  data_dm_i;
    logic           halted;
    logic [DW-1:0]  acc;

    always #5 clk = ~clk;

    processor_param #(.DATA_W(DW), .IM_AW(IAW), .DM_AW(DAW)) dut (
        .CLOCK_i(clk), .RESET_i(rst), .HOLD_n_i(hold_n),
        .ADDR_im_o(addr_im), .DATA_im_i(data_im),
        .CEnable_im_o(ce_im), .OEnable_im_o(oe_im),
        .CEnable_dm_o(ce_dm), .OEnable_dm_o(oe_dm), .WEnable_dm_o(we_dm),
        .ADDR_dm_o(addr_dm), .DATA_dm_o(data_dm_o), .DATA_dm_i(data_dm_i),
        .DM_READY_i(dm_ready), .HALTED_o(halted), .ACC_o(acc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Memories: program, initial data image, live data memory, write log
    logic [DW-1:0]      im_mem  [0:1023];
    logic [DW-1:0]      dm_init [0:2047];
    logic [DW-1:0]      dm_mem  [0:2047];
    logic [DAW+DW-1:0]  wr_log  [$];
    int                 cyc = 0;
    int                 hold_total = 0;
    int                 dm_wait = 0;
    int                 wait_left = 0;

    assign data_dm_i = dm_mem[addr_dm];

    // Synchronous memory behaviour and event counters
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            for (int i = 0; i < 2048; i++) dm_mem[i] = dm_init[i];
        end else begin
            if (!hold_n) hold_total = hold_total + 1;
            if (!ce_im && !oe_im) data_im <= im_mem[addr_im];
            if (!ce_dm && !we_dm && dm_ready) begin
                dm_mem[addr_dm] = data_dm_o;
                wr_log.push_back({addr_dm, data_dm_o});
            end
        end
    end

    // Data memory inserts dm_wait not-ready cycles at the start of every access
    always @(negedge clk) begin
        if (!ce_dm) begin
            if (wait_left > 0) begin
                dm_ready = 1'b0;
                wait_left = wait_left - 1;
            end else begin
                dm_ready = 1'b1;
            end
        end else begin
            dm_ready = 1'b1;
            wait_left = dm_wait;
        end
    end

    // Instruction-set model
    logic [IAW-1:0]     m_pc;
    logic [DW-1:0]      m_acc;
    bit                 m_z, m_n, m_c, m_halt;
    logic [DW-1:0]      mdl_dm [0:2047];
    int                 exp_cpi, fetch_cyc, hold_snap, rd_idx;
    bit                 exp_wr, have_prev;
    logic [DAW+DW-1:0]  exp_wr_val;
    logic [IAW-1:0]     fpc_log [$];
    logic [DW-1:0]      facc_log [$];
    logic [DW-1:0]      ins, mval;
    logic [3:0]         op;
    logic [DW-5:0]      opnd;
    logic [DAW-1:0]     maddr;
    logic [DW:0]        wide;
    bit                 acc_wr;
    bit                 halt_due;

    // Compare process: per-cycle invariants, and per-fetch architectural state against the model
    always @(negedge clk) begin
        if (rst) begin
            m_pc = '0; m_acc = '0; m_z = 0; m_n = 0; m_c = 0; m_halt = 0;
            have_prev = 0; fetch_cyc = cyc; exp_cpi = 0; exp_wr = 0;
            rd_idx = wr_log.size();
            fpc_log.delete(); facc_log.delete();
            for (int i = 0; i < 2048; i++) mdl_dm[i] = dm_init[i];
        end else begin
            check("dm_oe_we_exclusive", {31'b0, oe_dm | we_dm}, 32'd1);
            halt_due = m_halt && ((cyc - fetch_cyc) >= 3);
            check("halted", {31'b0, halted}, {31'b0, halt_due});
            if (halt_due)
                check("halt_enables", {27'b0, ce_im, oe_im, ce_dm, oe_dm, we_dm}, 32'h1f);
            if (!ce_im && !oe_im) begin
                check("fetch_pc", {22'b0, addr_im}, {22'b0, m_pc});
                check("fetch_acc", {16'b0, acc}, {16'b0, m_acc});
                if (have_prev) begin
                    check("cycles_per_instr", cyc - fetch_cyc, exp_cpi + hold_total - hold_snap);
                    if (exp_wr) begin
                        check("write_count", wr_log.size() - rd_idx, 1);
                        if (wr_log.size() > rd_idx)
                            check("write_addr_data", {5'b0, wr_log[rd_idx]}, {5'b0, exp_wr_val});
                    end else begin
                        check("write_count", wr_log.size() - rd_idx, 0);
                    end
                end
                rd_idx = wr_log.size();
                fpc_log.push_back(m_pc);
                facc_log.push_back(m_acc);
                // execute one instruction of the model
                ins   = im_mem[m_pc];
                op    = ins[DW-1:DW-4];
                opnd  = ins[DW-5:0];
                maddr = opnd[DAW-1:0];
                mval  = mdl_dm[maddr];
                m_pc  = m_pc + 1'b1;
                exp_cpi = 3; exp_wr = 0; acc_wr = 0;
                case (op)
                    4'h1: begin m_acc = {4'b0, opnd}; m_c = 0; acc_wr = 1; end
                    4'h2: begin m_acc = mval; m_c = 0; acc_wr = 1; exp_cpi = 4 + dm_wait; end
                    4'h3: begin
                        mdl_dm[maddr] = m_acc; exp_wr = 1; exp_wr_val = {maddr, m_acc};
                        exp_cpi = 3 + dm_wait;
                    end
                    4'h4: begin
                        wide = m_acc + mval; m_acc = wide[DW-1:0]; m_c = wide[DW];
                        acc_wr = 1; exp_cpi = 4 + dm_wait;
                    end
                    4'h5: begin
                        wide = {1'b0, m_acc} - {1'b0, mval}; m_acc = wide[DW-1:0]; m_c = wide[DW];
                        acc_wr = 1; exp_cpi = 4 + dm_wait;
                    end
                    4'h6: begin m_acc = m_acc & mval; m_c = 0; acc_wr = 1; exp_cpi = 4 + dm_wait; end
                    4'h7: begin m_acc = m_acc | mval; m_c = 0; acc_wr = 1; exp_cpi = 4 + dm_wait; end
                    4'h8: begin m_acc = m_acc ^ mval; m_c = 0; acc_wr = 1; exp_cpi = 4 + dm_wait; end
                    4'h9: m_pc = opnd[IAW-1:0];
                    4'hA: if (m_z) m_pc = opnd[IAW-1:0];
                    4'hB: if (m_n) m_pc = opnd[IAW-1:0];
                    4'hC: if (m_c) m_pc = opnd[IAW-1:0];
                    4'hF: m_halt = 1;
                    default: ;
                endcase
                if (acc_wr) begin
                    m_z = (m_acc == '0);
                    m_n = m_acc[DW-1];
                end
                fetch_cyc = cyc;
                hold_snap = hold_total;
                have_prev = 1;
            end
        end
    end

    int t0;

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) im_mem[i] = '0;
        for (int i = 0; i < 2048; i++) dm_init[i] = '0;
    endtask

    task automatic start();
        rst = 1'b1;
        hold_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_enables", {27'b0, ce_im, oe_im, ce_dm, oe_dm, we_dm}, 32'h1f);
        check("rst_halted", {31'b0, halted}, 32'd0);
        check("rst_addr_im", {22'b0, addr_im}, 32'd0);
        check("rst_acc", {16'b0, acc}, 32'd0);
        check("rst_addr_dm", {21'b0, addr_dm}, 32'd0);
        check("rst_data_dm", {16'b0, data_dm_o}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        t0 = cyc;
    endtask

    task automatic run_to_halt(input int max_cyc, output int took);
        int n;
        n = 0;
        while (!halted && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("halt_reached", {31'b0, halted}, 32'd1);
        took = cyc - t0;
    endtask

    int took, n_ce, n_oe_hi, last_mem, acc_cyc, wcount;

    initial begin
        // Program 1: LDI 5; ADD [3]; ST [4]; HALT
        clear_mem();
        dm_wait = 0;
        im_mem[0] = 16'h1005; im_mem[1] = 16'h4003; im_mem[2] = 16'h3004; im_mem[3] = 16'hF000;
        dm_init[3] = 16'h000B;
        start();
        run_to_halt(60, took);
        check("p1_halt_cycles", took, 13);
        check("p1_mem4", {16'b0, dm_mem[4]}, 32'h0010);
        check("p1_acc", {16'b0, acc}, 32'h0010);

        // Program 2: carry/zero/negative driven branches and the logic ops
        clear_mem();
        im_mem[0]    = 16'h1FFF; im_mem[1]    = 16'h4000; im_mem[2]    = 16'hC020;
        im_mem[10'h20] = 16'hA030;
        im_mem[10'h30] = 16'hB040; im_mem[10'h31] = 16'h5005; im_mem[10'h32] = 16'hB050;
        im_mem[10'h50] = 16'h6006; im_mem[10'h51] = 16'hC060; im_mem[10'h52] = 16'h7007;
        im_mem[10'h53] = 16'h8007; im_mem[10'h54] = 16'h2008; im_mem[10'h55] = 16'hD000;
        im_mem[10'h56] = 16'hF000;
        dm_init[0] = 16'hF001; dm_init[5] = 16'h0001; dm_init[6] = 16'h00FF;
        dm_init[7] = 16'h0F00; dm_init[8] = 16'h8000;
        start();
        run_to_halt(200, took);
        check("p2_fetch_count", fpc_log.size(), 14);
        if (fpc_log.size() >= 14) begin
            check("p2_acc_after_add", {16'b0, facc_log[2]}, 32'h0000);
            check("p2_jc_target", {22'b0, fpc_log[3]}, 32'h020);
            check("p2_jn_not_taken", {22'b0, fpc_log[5]}, 32'h031);
            check("p2_jn_taken", {22'b0, fpc_log[7]}, 32'h050);
            check("p2_jc_not_taken", {22'b0, fpc_log[9]}, 32'h052);
        end
        check("p2_acc_final", {16'b0, acc}, 32'h8000);

        // Program 3: LD with three wait states
        clear_mem();
        dm_wait = 3;
        im_mem[0] = 16'h2009; im_mem[1] = 16'hF000;
        dm_init[9] = 16'h1234;
        start();
        n_ce = 0; n_oe_hi = 0; last_mem = 0; acc_cyc = -1;
        for (int i = 0; i < 40 && !halted; i++) begin
            @(negedge clk);
            if (!ce_dm) begin
                n_ce++;
                if (oe_dm) n_oe_hi++;
                last_mem = cyc;
            end
            if (acc == 16'h1234 && acc_cyc < 0) acc_cyc = cyc;
        end
        check("p3_halt_reached", {31'b0, halted}, 32'd1);
        check("p3_mem_cycles", n_ce, 4);
        check("p3_oe_low_throughout", n_oe_hi, 0);
        check("p3_acc_after_ready", acc_cyc - last_mem, 2);

        // Program 4: hold for five cycles while ADD is in DECODE
        clear_mem();
        dm_wait = 0;
        im_mem[0] = 16'h1123; im_mem[1] = 16'h4003; im_mem[2] = 16'hF000;
        dm_init[3] = 16'h0001;
        start();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!ce_im && addr_im == 10'd1) break;
        end
        @(negedge clk);
        hold_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_addr_im", {22'b0, addr_im}, 32'd1);
            check("hold_enables", {27'b0, ce_im, oe_im, ce_dm, oe_dm, we_dm}, 32'h1f);
            check("hold_acc", {16'b0, acc}, 32'h0123);
        end
        hold_n = 1'b1;
        run_to_halt(60, took);
        check("p4_acc_final", {16'b0, acc}, 32'h0124);

        // Program 5: PC wrap from 0x3FF to 0
        clear_mem();
        im_mem[0] = 16'h93FF; im_mem[10'h3FF] = 16'h0000;
        start();
        repeat (15) @(negedge clk);
        check("p5_fetch_count", fpc_log.size(), 5);
        if (fpc_log.size() >= 3) begin
            check("p5_jump_to_top", {22'b0, fpc_log[1]}, 32'h3FF);
            check("p5_wrap_to_zero", {22'b0, fpc_log[2]}, 32'h000);
        end

        // Program 6: reset while ST waits in MEM
        clear_mem();
        dm_wait = 2;
        im_mem[0] = 16'h1077; im_mem[1] = 16'h300A; im_mem[2] = 16'hF000;
        start();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!ce_dm && !we_dm) break;
        end
        check("p6_in_store", {30'b0, ce_dm, we_dm}, 32'd0);
        wcount = wr_log.size();
        #1 rst = 1'b1;
        #1;
        check("p6_we_released", {31'b0, we_dm}, 32'd1);
        check("p6_ce_released", {31'b0, ce_dm}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        t0 = cyc;
        @(negedge clk);
        check("p6_no_write", wr_log.size(), wcount);
        check("p6_addr_im", {22'b0, addr_im}, 32'd0);
        check("p6_acc", {16'b0, acc}, 32'd0);
        run_to_halt(60, took);
        check("p6_store_after_restart", {16'b0, dm_mem[10'hA]}, 32'h0077);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/processor_param.md
PROCESSOR_PARAM -- requirements
Module: processor_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16: data and instruction word width; opcode is bits [DATA_W-1:DATA_W-4] and operand is bits [DATA_W-5:0].
REQ-002 SHALL have parameter IM_AW, default 10: instruction memory address width; IM_AW <= DATA_W-4.
REQ-003 SHALL have parameter DM_AW, default 11: data memory address width; DM_AW <= DATA_W-4.
REQ-004 SHALL have port CLOCK_i, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-005 SHALL have port RESET_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port HOLD_n_i, input, 1 bit: active-low freeze.
REQ-007 SHALL have port ADDR_im_o, output, IM_AW bits: instruction address (equals PC).
REQ-008 SHALL have port DATA_im_i, input, DATA_W bits: instruction word, valid one cycle after the enables are asserted.
REQ-009 SHALL have ports CEnable_im_o and OEnable_im_o, outputs, 1 bit each: instruction memory chip enable and output enable, active low.
REQ-010 SHALL have ports CEnable_dm_o, OEnable_dm_o and WEnable_dm_o, outputs, 1 bit each: data memory chip, output and write enables, active low.
REQ-011 SHALL have port ADDR_dm_o, output, DM_AW bits: data address, taken from operand[DM_AW-1:0].
REQ-012 SHALL have port DATA_dm_o, output, DATA_W bits: store data (ACC).
REQ-013 SHALL have port DATA_dm_i, input, DATA_W bits: load data.
REQ-014 SHALL have port DM_READY_i, input, 1 bit: data memory ready, active high, for wait-state insertion.
REQ-015 SHALL have port HALTED_o, output, 1 bit: high while in the HALT state.
REQ-016 SHALL have port ACC_o, output, DATA_W bits: accumulator value, for observation.

Function
REQ-017 SHALL implement the FSM states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-018 FETCH: SHALL drive CEnable_im_o and OEnable_im_o low, then go to DECODE.
REQ-019 DECODE: SHALL latch IR <= DATA_im_i and PC <= PC+1 (modulo 2^IM_AW), then go to MEM for LD/ST/ADD/SUB/AND/OR/XOR and to EXEC otherwise.
REQ-020 SHALL use opcodes 0 NOP, 1 LDI, 2 LD, 3 ST, 4 ADD, 5 SUB, 6 AND, 7 OR, 8 XOR, 9 JMP, A JZ, B JN, C JC, F HALT.
REQ-021 SHALL execute the undefined opcodes D and E as NOP.
REQ-022 EXEC: LDI SHALL set ACC <= zero-extended operand.
REQ-023 EXEC: JMP SHALL set PC <= operand[IM_AW-1:0].
REQ-024 EXEC: JZ, JN and JC SHALL load the jump target only if Z, N or C respectively is set.
REQ-025 EXEC: HALT SHALL go to the HALT state.
REQ-026 EXEC: all other opcodes SHALL return to FETCH.
REQ-027 MEM: SHALL drive CEnable_dm_o low, with OEnable_dm_o low for reads or WEnable_dm_o low for ST, and SHALL remain in MEM while DM_READY_i=0.
REQ-028 MEM, on DM_READY_i=1: ST SHALL complete and go to FETCH; reads SHALL capture MDR <= DATA_dm_i and go to WB.
REQ-029 WB: SHALL set ACC <= MDR for LD, ACC op MDR for ALU opcodes, then go to FETCH.
REQ-030 ADD/SUB SHALL compute at DATA_W+1 bits; C = bit DATA_W (for SUB, C=1 means borrow); AND/OR/XOR/LD/LDI SHALL clear C.
REQ-031 Z (ACC==0) and N (ACC MSB) SHALL update on every ACC write and hold otherwise.
REQ-032 Minimum cycles per instruction SHALL be: non-memory 3, ST 3, LD/ALU 4; each DM_READY_i=0 cycle adds one.
REQ-033 All memory enables SHALL be high in every state not listed as asserting them; at most one of OEnable_dm_o/WEnable_dm_o SHALL be low at any time.
REQ-034 HOLD_n_i=0 SHALL freeze the state, PC, IR, ACC, MDR and flags, holding all outputs at their current values; execution SHALL resume from the same state on release.
REQ-035 HALT SHALL keep all enables high and HALTED_o=1 until reset; HOLD_n_i has no effect in HALT.
REQ-036 PC SHALL wrap from 2^IM_AW-1 to 0 with no fault.

Reset
REQ-037 RESET_i=1 SHALL immediately force state FETCH, PC=0, IR=0, ACC=0, MDR=0, flags=0, HALTED_o=0, ADDR_dm_o=0, DATA_dm_o=0 and all enables high, regardless of the clock.
REQ-038 Reset asserted during MEM SHALL abort the access, with the enables high asynchronously.
REQ-039 On reset release, the first rising edge SHALL be spent in FETCH with ADDR_im_o=0.

Verification
REQ-040 Program LDI 5; ADD [3] with M[3]=0x000B; ST [4]; HALT -> M[4]=0x0010, Z=0, C=0, HALTED_o=1 after 3+4+3+3 cycles.
REQ-041 LDI 0xFFF; ADD [0] with M[0]=0xF001 -> ACC=0x0000, Z=1, C=1; a following JC 0x020 -> PC=0x020.
REQ-042 LD with DM_READY_i held low for 3 cycles -> MEM lasts 4 cycles with CEnable_dm_o and OEnable_dm_o low throughout, and ACC updates exactly 1 cycle after ready.
REQ-043 HOLD_n_i low for 5 cycles during DECODE -> ADDR_im_o, the enables and ACC are unchanged and the instruction completes normally after release.
REQ-044 PC=0x3FF executing NOP -> the next fetch has ADDR_im_o=0x000.
REQ-045 RESET_i pulsed mid-ST in MEM -> WEnable_dm_o goes high within the same cycle, there is no write, and after release ADDR_im_o=0 and ACC=0.
